// File: rtl/turn_sched_pkg.sv
// Shared definitions for the memory-game turn scheduler.
// Holds the FSM state encoding, the result codes shown on the result port,
// the board index width and the helper that decides the winner.
package turn_sched_pkg;

  localparam int IDX_W = 4;
  localparam int VAL_W = 4;
  localparam int SCORE_W = 4;

  typedef logic [IDX_W-1:0]   idx_t;
  typedef logic [VAL_W-1:0]   val_t;
  typedef logic [SCORE_W-1:0] score_t;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_PICK1   = 3'd1,
    S_PICK2   = 3'd2,
    S_COMPARE = 3'd3,
    S_SHOW    = 3'd4,
    S_OVER    = 3'd5
  } state_t;

  localparam logic [1:0] RES_NONE = 2'b00;
  localparam logic [1:0] RES_P1   = 2'b01;
  localparam logic [1:0] RES_P2   = 2'b10;
  localparam logic [1:0] RES_TIE  = 2'b11;

  function automatic logic [1:0] calc_result(input score_t s1, input score_t s2);
    if (s1 > s2)      return RES_P1;
    else if (s2 > s1) return RES_P2;
    else              return RES_TIE;
  endfunction

endpackage

// File: rtl/turn_sched_timer.sv
// cycle_timer: loadable down-counter with terminal-count expire pulse.
// Ports:
//   clk, rst        clock, asynchronous active-low reset (clears the count)
//   i_load          load i_load_val into the counter (wins over counting)
//   i_load_val      number of counting cycles until expiry
//   i_count         decrement enable
//   o_expire        high for the single counting cycle in which the count is 1
// A load of N followed by N counting cycles gives o_expire on the Nth cycle.
// A load value of 0 never expires.
module cycle_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_count,
  output logic         o_expire
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_count && (r_cnt != '0)) begin
      r_cnt <= r_cnt - W'(1);
    end
  end

  assign o_expire = i_count && (r_cnt == W'(1));

endmodule

// File: rtl/turn_sched.sv
// turn_sched: two-player memory-game turn scheduler.
// Sequences card picks, compares the two revealed symbols, keeps scores,
// alternates turns and forfeits idle turns. Board storage is external.
// Ports:
//   clk, rst            clock, asynchronous active-low reset
//   start               pulse: begin/restart a game (IDLE or OVER only)
//   select, card_idx    pulse: pick the card at card_idx
//   card_val            symbol at card_idx (combinational from board)
//   card_avail          card at card_idx is face-down and unmatched
//   reveal_en/idx       pulse: turn card reveal_idx face-up
//   hide_en             pulse: turn idx_a and idx_b face-down
//   match_en            pulse: mark idx_a and idx_b matched
//   idx_a, idx_b        held pick positions
//   player              current turn (0 = player 1)
//   score1, score2      pairs won per player
//   result              00 play/idle, 01 P1 wins, 10 P2 wins, 11 tie
//
// state   | meaning
// IDLE    | waiting for start
// PICK1   | waiting for first card of the turn
// PICK2   | waiting for second card of the turn
// COMPARE | one cycle: judge the pair
// SHOW    | mismatched pair face-up for SHOW_CYCLES
// OVER    | all pairs won, result held until start
module turn_sched
  import turn_sched_pkg::*;
#(
  parameter int PAIRS        = 8,
  parameter int SHOW_CYCLES  = 50_000_000,
  parameter int TURN_TIMEOUT = 500_000_000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             select,
  input  logic [IDX_W-1:0] card_idx,
  input  logic [VAL_W-1:0] card_val,
  input  logic             card_avail,
  output logic             reveal_en,
  output logic [IDX_W-1:0] reveal_idx,
  output logic             hide_en,
  output logic             match_en,
  output logic [IDX_W-1:0] idx_a,
  output logic [IDX_W-1:0] idx_b,
  output logic             player,
  output logic [3:0]       score1,
  output logic [3:0]       score2,
  output logic [1:0]       result
);

  localparam int TMR_MAX = (SHOW_CYCLES > TURN_TIMEOUT) ? SHOW_CYCLES : TURN_TIMEOUT;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);
  localparam logic [TMR_W-1:0] SHOW_LOAD = TMR_W'(SHOW_CYCLES);
  localparam logic [TMR_W-1:0] TURN_LOAD = TMR_W'(TURN_TIMEOUT);
  localparam score_t           P_MAX     = SCORE_W'(PAIRS);
  localparam logic [SCORE_W:0] P_SUM     = (SCORE_W+1)'(PAIRS);

  state_t r_state, w_state_nxt;

  idx_t   r_idx_a, r_idx_b, r_reveal_idx;
  val_t   r_val_a, r_val_b;
  logic   r_reveal_en, r_hide_en, r_match_en;
  logic   r_player;
  score_t r_score1, r_score2;
  logic [1:0] r_result;

  logic w_start_ok, w_sel_ok, w_expire, w_timeout, w_match, w_game_done;
  logic w_reveal_nxt, w_hide_nxt, w_match_nxt, w_toggle;
  logic w_tmr_load, w_tmr_count;
  logic [TMR_W-1:0] w_tmr_val;
  score_t w_s1_nxt, w_s2_nxt;
  logic [SCORE_W:0] w_total;

  assign w_start_ok = start && ((r_state == S_IDLE) || (r_state == S_OVER));
  assign w_sel_ok   = select && card_avail &&
                      ((r_state == S_PICK1) ||
                       ((r_state == S_PICK2) && (card_idx != r_idx_a)));
  // An accepted select in the same cycle as expiry wins and reloads the timer.
  assign w_timeout  = w_expire && !w_sel_ok &&
                      ((r_state == S_PICK1) || (r_state == S_PICK2));
  assign w_match    = (r_val_a == r_val_b);

  // Post-increment scores for the current player, saturating at PAIRS.
  always_comb begin
    w_s1_nxt = r_score1;
    w_s2_nxt = r_score2;
    if (r_player == 1'b0) w_s1_nxt = (r_score1 >= P_MAX) ? P_MAX : r_score1 + SCORE_W'(1);
    else                  w_s2_nxt = (r_score2 >= P_MAX) ? P_MAX : r_score2 + SCORE_W'(1);
  end

  assign w_total     = {1'b0, w_s1_nxt} + {1'b0, w_s2_nxt};
  assign w_game_done = (w_total == P_SUM);

  // Shared timer: SHOW duration and per-pick turn timeout never overlap.
  cycle_timer #(.W(TMR_W)) u_timer (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_tmr_load),
    .i_load_val (w_tmr_val),
    .i_count    (w_tmr_count),
    .o_expire   (w_expire)
  );

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:    if (w_start_ok) w_state_nxt = S_PICK1;
      S_PICK1:   if (w_sel_ok) w_state_nxt = S_PICK2;
      S_PICK2:   if (w_sel_ok) w_state_nxt = S_COMPARE;
                 else if (w_timeout) w_state_nxt = S_PICK1;
      S_COMPARE: if (!w_match) w_state_nxt = S_SHOW;
                 else if (w_game_done) w_state_nxt = S_OVER;
                 else w_state_nxt = S_PICK1;
      S_SHOW:    if (w_expire) w_state_nxt = S_PICK1;
      S_OVER:    if (w_start_ok) w_state_nxt = S_PICK1;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  // Output / control logic (pulses are registered below)
  always_comb begin
    w_reveal_nxt = w_sel_ok;
    w_hide_nxt   = ((r_state == S_SHOW) && w_expire) ||
                   ((r_state == S_PICK2) && w_timeout);
    w_match_nxt  = (r_state == S_COMPARE) && w_match;
    w_toggle     = w_timeout || ((r_state == S_SHOW) && w_expire);
    w_tmr_count  = (r_state == S_PICK1) || (r_state == S_PICK2) || (r_state == S_SHOW);
    // Reload on every entry to PICK1/PICK2 (including the timeout self-loop),
    // on every accepted select, and when COMPARE hands over to SHOW.
    w_tmr_load   = w_start_ok || w_sel_ok || (r_state == S_COMPARE) ||
                   (w_expire && w_tmr_count);
    w_tmr_val    = ((r_state == S_COMPARE) && !w_match) ? SHOW_LOAD : TURN_LOAD;
  end

  // Datapath and registered pulses
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_reveal_en  <= 1'b0;
      r_hide_en    <= 1'b0;
      r_match_en   <= 1'b0;
      r_reveal_idx <= '0;
      r_idx_a      <= '0;
      r_idx_b      <= '0;
      r_val_a      <= '0;
      r_val_b      <= '0;
      r_player     <= 1'b0;
      r_score1     <= '0;
      r_score2     <= '0;
      r_result     <= RES_NONE;
    end else begin
      r_reveal_en <= w_reveal_nxt;
      r_hide_en   <= w_hide_nxt;
      r_match_en  <= w_match_nxt;
      if (w_start_ok) begin
        r_player <= 1'b0;
        r_score1 <= '0;
        r_score2 <= '0;
        r_result <= RES_NONE;
      end else begin
        if (w_toggle) r_player <= ~r_player;
        if ((r_state == S_COMPARE) && w_match) begin
          r_score1 <= w_s1_nxt;
          r_score2 <= w_s2_nxt;
          if (w_game_done) r_result <= calc_result(w_s1_nxt, w_s2_nxt);
        end
      end
      if (w_sel_ok) begin
        r_reveal_idx <= card_idx;
        if (r_state == S_PICK1) begin
          r_idx_a <= card_idx;
          r_val_a <= card_val;
        end else begin
          r_idx_b <= card_idx;
          r_val_b <= card_val;
        end
      end
      // Forfeit with one card up: hide only that card.
      if ((r_state == S_PICK2) && w_timeout) r_idx_b <= r_idx_a;
    end
  end

  assign reveal_en  = r_reveal_en;
  assign reveal_idx = r_reveal_idx;
  assign hide_en    = r_hide_en;
  assign match_en   = r_match_en;
  assign idx_a      = r_idx_a;
  assign idx_b      = r_idx_b;
  assign player     = r_player;
  assign score1     = r_score1;
  assign score2     = r_score2;
  assign result     = r_result;

endmodule

// File: tb/tb_turn_sched.sv
// Directed self-checking bench for turn_sched (PAIRS=2, SHOW=4, TIMEOUT=8).
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_turn_sched;

  logic       clk = 1'b0;
  logic       rst;
  logic       start, select, card_avail;
  logic [3:0] card_idx, card_val;
  logic       reveal_en, hide_en, match_en, player;
  logic [3:0] reveal_idx, idx_a, idx_b, score1, score2;
  logic [1:0] result;

  int n_checks = 0;
  int n_fail   = 0;

  turn_sched #(.PAIRS(2), .SHOW_CYCLES(4), .TURN_TIMEOUT(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .select     (select),
    .card_idx   (card_idx),
    .card_val   (card_val),
    .card_avail (card_avail),
    .reveal_en  (reveal_en),
    .reveal_idx (reveal_idx),
    .hide_en    (hide_en),
    .match_en   (match_en),
    .idx_a      (idx_a),
    .idx_b      (idx_b),
    .player     (player),
    .score1     (score1),
    .score2     (score2),
    .result     (result)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic pick(input logic [3:0] idx, input logic [3:0] val, input logic avail);
    select     = 1'b1;
    card_idx   = idx;
    card_val   = val;
    card_avail = avail;
    tick();
    select     = 1'b0;
    card_avail = 1'b0;
  endtask

  // Mismatch wait: hide_en must rise exactly 4 edges after the COMPARE cycle.
  task automatic show_wait(input string tag, input logic exp_player);
    for (int k = 1; k <= 5; k++) begin
      tick();
      chk($sformatf("%s_hide_k%0d", tag, k), 32'(hide_en), 32'(k == 5));
    end
    chk({tag, "_player"}, 32'(player), 32'(exp_player));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic hide_seen;
    rst = 1'b0; start = 1'b0; select = 1'b0;
    card_idx = '0; card_val = '0; card_avail = 1'b0;
    repeat (2) tick();
    chk("rst_score1", 32'(score1), 0);
    chk("rst_result", 32'(result), 0);
    chk("rst_pulses", 32'({reveal_en, hide_en, match_en}), 0);
    rst = 1'b1;
    tick();

    // select in IDLE is ignored
    pick(4'd1, 4'd1, 1'b1);
    chk("idle_sel_reveal", 32'(reveal_en), 0);

    pulse_start();
    chk("start_player", 32'(player), 0);
    chk("start_result", 32'(result), 0);

    // Match: idx3 val5, idx9 val5
    pick(4'd3, 4'd5, 1'b1);
    chk("p1_reveal", 32'(reveal_en), 1);
    chk("p1_reveal_idx", 32'(reveal_idx), 3);
    chk("p1_idx_a", 32'(idx_a), 3);
    pick(4'd3, 4'd5, 1'b1);
    chk("same_idx_reveal", 32'(reveal_en), 0);
    pick(4'd9, 4'd5, 1'b0);
    chk("unavail_reveal", 32'(reveal_en), 0);
    pick(4'd9, 4'd5, 1'b1);
    chk("p2_reveal", 32'(reveal_en), 1);
    chk("p2_reveal_idx", 32'(reveal_idx), 9);
    chk("p2_idx_b", 32'(idx_b), 9);
    tick();
    chk("m1_match_en", 32'(match_en), 1);
    chk("m1_score1", 32'(score1), 1);
    chk("m1_player", 32'(player), 0);

    // Mismatch: val 2 vs val 7
    pick(4'd0, 4'd2, 1'b1);
    pick(4'd1, 4'd7, 1'b1);
    show_wait("mm1", 1'b1);
    chk("mm1_score1", 32'(score1), 1);

    // Turn timeout with one card up (player 1)
    pick(4'd4, 4'd3, 1'b1);
    for (int k = 1; k <= 8; k++) begin
      tick();
      chk($sformatf("to_hide_k%0d", k), 32'(hide_en), 32'(k == 8));
    end
    chk("to_player", 32'(player), 0);
    chk("to_idx_b", 32'(idx_b), 4);

    // Player 1 wins second pair -> 2-0, game over
    pick(4'd5, 4'd6, 1'b1);
    pick(4'd6, 4'd6, 1'b1);
    tick();
    chk("win_match_en", 32'(match_en), 1);
    chk("win_score1", 32'(score1), 2);
    chk("win_result", 32'(result), 1);
    pick(4'd7, 4'd1, 1'b1);
    chk("over_sel_reveal", 32'(reveal_en), 0);
    chk("over_result_held", 32'(result), 1);

    // Restart, then tie 1-1
    pulse_start();
    chk("restart_score1", 32'(score1), 0);
    chk("restart_result", 32'(result), 0);
    pick(4'd1, 4'd4, 1'b1);
    pick(4'd2, 4'd4, 1'b1);
    tick();
    chk("tie_score1", 32'(score1), 1);
    pulse_start();
    chk("start_ignored_score1", 32'(score1), 1);
    pick(4'd3, 4'd1, 1'b1);
    pick(4'd4, 4'd2, 1'b1);
    show_wait("mm2", 1'b1);
    pick(4'd3, 4'd1, 1'b1);
    pick(4'd5, 4'd1, 1'b1);
    tick();
    chk("tie_score2", 32'(score2), 1);
    chk("tie_player", 32'(player), 1);
    chk("tie_result", 32'(result), 3);

    // Reset during SHOW
    pulse_start();
    pick(4'd5, 4'd3, 1'b1);
    pick(4'd6, 4'd3, 1'b1);
    tick();
    chk("pre_rst_score1", 32'(score1), 1);
    pick(4'd7, 4'd1, 1'b1);
    pick(4'd8, 4'd2, 1'b1);
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk("mid_rst_score1", 32'(score1), 0);
    chk("mid_rst_idx_a", 32'(idx_a), 0);
    chk("mid_rst_idx_b", 32'(idx_b), 0);
    chk("mid_rst_pulses", 32'({reveal_en, hide_en, match_en}), 0);
    tick();
    rst = 1'b1;
    hide_seen = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (hide_en) hide_seen = 1'b1;
    end
    chk("post_rst_no_hide", 32'(hide_seen), 0);
    pick(4'd2, 4'd2, 1'b1);
    chk("post_rst_idle_sel", 32'(reveal_en), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
